// File: rtl/lsu.sv
// rv32 load/store unit: single-outstanding req/ack data-memory port,
// lane-formatted stores and sign/zero-extended loads with fault detection.
module lsu #(
  parameter int WORD_LENGTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   is_store,
  input  logic [2:0]             funct3,
  input  logic [WORD_LENGTH-1:0] addr,
  input  logic [WORD_LENGTH-1:0] store_data,
  output logic                   busy,
  output logic                   done,
  output logic                   fault,
  output logic [WORD_LENGTH-1:0] load_data,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [WORD_LENGTH-1:0] mem_addr,
  output logic [3:0]             mem_be,
  output logic [WORD_LENGTH-1:0] mem_wdata,
  input  logic                   mem_ack,
  input  logic [WORD_LENGTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP
  } state_t;

  state_t state, state_nx;

  logic                   st_q;
  logic [2:0]             f3_q;
  logic [1:0]             off_q;
  logic                   legal;
  logic                   misal;
  logic                   accept;
  logic                   bad;
  logic [3:0]             be_nx;
  logic [WORD_LENGTH-1:0] wdata_nx;
  logic [WORD_LENGTH-1:0] ext;
  logic [7:0]             lb;
  logic [15:0]            lh;

  always_comb begin
    legal = 1'b0;
    case (funct3)
      3'b000, 3'b001, 3'b010: legal = 1'b1;
      3'b100, 3'b101:         legal = !is_store;
      default:                legal = 1'b0;
    endcase
  end

  assign misal  = ((funct3[1:0] == 2'b01) && addr[0]) ||
                  ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
  assign accept = (state == IDLE) && start && legal && !misal;
  assign bad    = (state == IDLE) && start && !(legal && !misal);

  always_comb begin
    be_nx    = 4'b1111;
    wdata_nx = store_data;
    case (funct3[1:0])
      2'b00: begin
        be_nx    = 4'b0001 << addr[1:0];
        wdata_nx = {4{store_data[7:0]}};
      end
      2'b01: begin
        be_nx    = 4'b0011 << addr[1:0];
        wdata_nx = {2{store_data[15:0]}};
      end
      default: begin
        be_nx    = 4'b1111;
        wdata_nx = store_data;
      end
    endcase
  end

  // funct3[2] selects zero-extension (LBU/LHU)
  assign lb = mem_rdata[8*off_q +: 8];
  assign lh = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    ext = mem_rdata;
    case (f3_q[1:0])
      2'b00:   ext = {{(WORD_LENGTH-8){lb[7] & ~f3_q[2]}}, lb};
      2'b01:   ext = {{(WORD_LENGTH-16){lh[15] & ~f3_q[2]}}, lh};
      default: ext = mem_rdata;
    endcase
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = REQ;
      REQ:     if (mem_ack) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      st_q      <= 1'b0;
      f3_q      <= 3'b000;
      off_q     <= 2'b00;
      fault     <= 1'b0;
      load_data <= '0;
      mem_addr  <= '0;
      mem_be    <= 4'b0000;
      mem_wdata <= '0;
    end else begin
      state <= state_nx;
      fault <= bad;
      if (accept) begin
        st_q      <= is_store;
        f3_q      <= funct3;
        off_q     <= addr[1:0];
        mem_addr  <= {addr[WORD_LENGTH-1:2], 2'b00};
        mem_be    <= be_nx;
        mem_wdata <= wdata_nx;
      end
      if ((state == REQ) && mem_ack && !st_q) load_data <= ext;
    end
  end

  assign busy    = (state != IDLE);
  assign done    = (state == RESP);
  assign mem_req = (state == REQ);
  assign mem_we  = (state == REQ) && st_q;

endmodule

// File: tb/tb_lsu.sv
// Directed self-checking bench for lsu: loads, stores, faults,
// wait states with re-asserted start, and async reset mid-request.
module tb_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        busy;
  logic        done;
  logic        fault;
  logic [31:0] load_data;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  lsu #(.WORD_LENGTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .is_store   (is_store),
    .funct3     (funct3),
    .addr       (addr),
    .store_data (store_data),
    .busy       (busy),
    .done       (done),
    .fault      (fault),
    .load_data  (load_data),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, "/busy"}, 32'(busy), 32'd0);
    chk({tag, "/done"}, 32'(done), 32'd0);
    chk({tag, "/req"}, 32'(mem_req), 32'd0);
  endtask

  task automatic do_load(input string tag, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] rd,
                         input logic [3:0] be, input logic [31:0] exp);
    start = 1'b1; is_store = 1'b0; funct3 = f3; addr = a;
    chk({tag, "/n_busy"}, 32'(busy), 32'd0);
    step();
    start = 1'b0;
    chk({tag, "/req"}, 32'(mem_req), 32'd1);
    chk({tag, "/we"}, 32'(mem_we), 32'd0);
    chk({tag, "/addr"}, mem_addr, {a[31:2], 2'b00});
    chk({tag, "/be"}, 32'(mem_be), 32'(be));
    chk({tag, "/n1_done"}, 32'(done), 32'd0);
    mem_ack = 1'b1; mem_rdata = rd;
    step();
    mem_ack = 1'b0; mem_rdata = 32'h0;
    chk({tag, "/done"}, 32'(done), 32'd1);
    chk({tag, "/fault"}, 32'(fault), 32'd0);
    chk({tag, "/data"}, load_data, exp);
    chk({tag, "/req_off"}, 32'(mem_req), 32'd0);
    step();
    idle_chk({tag, "/after"});
    chk({tag, "/hold"}, load_data, exp);
  endtask

  task automatic do_store(input string tag, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] sd,
                          input logic [3:0] be, input logic [31:0] wd,
                          input logic [31:0] ld_prev);
    start = 1'b1; is_store = 1'b1; funct3 = f3; addr = a; store_data = sd;
    step();
    start = 1'b0;
    chk({tag, "/req"}, 32'(mem_req), 32'd1);
    chk({tag, "/we"}, 32'(mem_we), 32'd1);
    chk({tag, "/addr"}, mem_addr, {a[31:2], 2'b00});
    chk({tag, "/be"}, 32'(mem_be), 32'(be));
    chk({tag, "/wdata"}, mem_wdata, wd);
    mem_ack = 1'b1; mem_rdata = 32'h5555_AAAA;
    step();
    mem_ack = 1'b0;
    chk({tag, "/done"}, 32'(done), 32'd1);
    chk({tag, "/we_off"}, 32'(mem_we), 32'd0);
    chk({tag, "/ld_keep"}, load_data, ld_prev);
    step();
    idle_chk({tag, "/after"});
  endtask

  task automatic do_fault(input string tag, input logic st,
                          input logic [2:0] f3, input logic [31:0] a);
    start = 1'b1; is_store = st; funct3 = f3; addr = a;
    chk({tag, "/n_fault"}, 32'(fault), 32'd0);
    step();
    start = 1'b0;
    chk({tag, "/fault"}, 32'(fault), 32'd1);
    idle_chk({tag, "/n1"});
    step();
    chk({tag, "/fault_off"}, 32'(fault), 32'd0);
    idle_chk({tag, "/n2"});
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; is_store = 1'b0; funct3 = 3'b000;
    addr = 32'h0; store_data = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
    #3;
    idle_chk("rst");
    chk("rst/fault", 32'(fault), 32'd0);
    chk("rst/we", 32'(mem_we), 32'd0);
    chk("rst/ld", load_data, 32'h0);
    chk("rst/maddr", mem_addr, 32'h0);
    chk("rst/be", 32'(mem_be), 32'd0);
    chk("rst/wdata", mem_wdata, 32'h0);
    step();
    step();
    reset = 1'b0;
    step();
    idle_chk("post_rst");
    chk("post_rst/ld", load_data, 32'h0);

    do_load("lw", 3'b010, 32'h100, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF);
    do_load("lb", 3'b000, 32'h103, 32'h80FF_0000, 4'b1000, 32'hFFFF_FF80);
    do_load("lbu", 3'b100, 32'h103, 32'h80FF_0000, 4'b1000, 32'h0000_0080);
    do_load("lb0", 3'b000, 32'h100, 32'h1234_567F, 4'b0001, 32'h0000_007F);
    do_load("lhu", 3'b101, 32'h100, 32'h1234_8001, 4'b0011, 32'h0000_8001);
    do_load("lh", 3'b001, 32'h102, 32'h80FF_0000, 4'b1100, 32'hFFFF_80FF);

    do_store("sh", 3'b001, 32'h202, 32'h1234_ABCD, 4'b1100,
             32'hABCD_ABCD, 32'hFFFF_80FF);
    do_store("sb", 3'b000, 32'h201, 32'h0000_00EF, 4'b0010,
             32'hEFEF_EFEF, 32'hFFFF_80FF);

    do_fault("lw_mis", 1'b0, 3'b010, 32'h101);
    do_fault("f3_011", 1'b0, 3'b011, 32'h100);
    do_fault("lh_mis", 1'b0, 3'b001, 32'h103);
    do_fault("sw_f3_100", 1'b1, 3'b100, 32'h200);
    chk("fault/ld_keep", load_data, 32'hFFFF_80FF);

    // SW with three wait cycles; start re-asserted mid-wait
    start = 1'b1; is_store = 1'b1; funct3 = 3'b010;
    addr = 32'h300; store_data = 32'hCAFE_F00D;
    step();
    start = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      if (i == 2) begin
        start = 1'b1; is_store = 1'b0; addr = 32'h500;
        store_data = 32'h1111_1111;
      end
      if (i == 3) start = 1'b0;
      if (i == 4) mem_ack = 1'b1;
      chk($sformatf("wait%0d/req", i), 32'(mem_req), 32'd1);
      chk($sformatf("wait%0d/we", i), 32'(mem_we), 32'd1);
      chk($sformatf("wait%0d/addr", i), mem_addr, 32'h300);
      chk($sformatf("wait%0d/wdata", i), mem_wdata, 32'hCAFE_F00D);
      chk($sformatf("wait%0d/done", i), 32'(done), 32'd0);
      step();
    end
    mem_ack = 1'b0;
    chk("wait/done", 32'(done), 32'd1);
    step();
    idle_chk("wait/after");
    chk("wait/addr_keep", mem_addr, 32'h300);
    step();
    idle_chk("wait/single");

    // Async reset while in REQ
    start = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h400;
    step();
    start = 1'b0;
    chk("arst/req_pre", 32'(mem_req), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("arst/req", 32'(mem_req), 32'd0);
    chk("arst/busy", 32'(busy), 32'd0);
    chk("arst/maddr", mem_addr, 32'h0);
    chk("arst/ld", load_data, 32'h0);
    step();
    reset = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'h7777_7777;
    step();
    mem_ack = 1'b0;
    idle_chk("arst/late_ack");
    chk("arst/ld_keep", load_data, 32'h0);
    step();
    do_load("lw2", 3'b010, 32'h404, 32'h0BAD_F00D, 4'b1111, 32'h0BAD_F00D);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
